// File: rtl/mio_mem_arbiter.sv
// Round-robin arbiter sharing a single-port data RAM between the CPU memory path and the
// VGA frame fetcher, with fixed-latency access sequencing and one-cycle completion pulses.
module mio_mem_arbiter #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          MIO_ready,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic [DW-1:0] vga_rdata,
  output logic          vga_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    grant
);

  localparam int unsigned   CntW    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MEM_LAT - 1);

  typedef enum logic [1:0] {StIdle, StCpuAcc, StVgaAcc} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            acc_we_q, acc_we_d;
  logic            last_cpu_q, last_cpu_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            mem_we_q, mem_we_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]   vga_rdata_q, vga_rdata_d;
  logic            mio_ready_q, mio_ready_d;
  logic            vga_ack_q, vga_ack_d;
  logic            pick_cpu, pick_vga;

  // Byte-offset bits of the CPU address are not used for word addressing.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cpu_addr[1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_we_d    = acc_we_q;
    last_cpu_d  = last_cpu_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vga_rdata_d = vga_rdata_q;
    mio_ready_d = 1'b0;
    vga_ack_d   = 1'b0;
    // On a tie the side that was not served last wins.
    pick_cpu    = cpu_req && (!vga_req || !last_cpu_q);
    pick_vga    = vga_req && !pick_cpu;

    unique case (state_q)
      StIdle: begin
        if (pick_cpu) begin
          state_d     = StCpuAcc;
          cnt_d       = CntLoad;
          acc_we_d    = cpu_we;
          mem_addr_d  = {2'b00, cpu_addr[AW-1:2]};
          mem_wdata_d = cpu_wdata;
          mem_we_d    = cpu_we;
        end else if (pick_vga) begin
          state_d     = StVgaAcc;
          cnt_d       = CntLoad;
          acc_we_d    = 1'b0;
          mem_addr_d  = vga_addr;
          mem_wdata_d = '0;
        end
      end
      StCpuAcc: begin
        if (cnt_q == '0) begin
          state_d     = StIdle;
          mio_ready_d = 1'b1;
          last_cpu_d  = 1'b1;
          if (!acc_we_q) begin
            cpu_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StVgaAcc: begin
        if (cnt_q == '0) begin
          state_d     = StIdle;
          vga_ack_d   = 1'b1;
          last_cpu_d  = 1'b0;
          vga_rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_we_q    <= 1'b0;
      last_cpu_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      cpu_rdata_q <= '0;
      vga_rdata_q <= '0;
      mio_ready_q <= 1'b0;
      vga_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_we_q    <= acc_we_d;
      last_cpu_q  <= last_cpu_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      cpu_rdata_q <= cpu_rdata_d;
      vga_rdata_q <= vga_rdata_d;
      mio_ready_q <= mio_ready_d;
      vga_ack_q   <= vga_ack_d;
    end
  end

  always_comb begin
    grant = 2'b00;
    unique case (state_q)
      StCpuAcc: grant = 2'b01;
      StVgaAcc: grant = 2'b10;
      default:  grant = 2'b00;
    endcase
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vga_rdata = vga_rdata_q;
  assign MIO_ready = mio_ready_q;
  assign vga_ack   = vga_ack_q;

endmodule

// File: tb/tb_mio_mem_arbiter.sv
// Bench for mio_mem_arbiter: three instances (MEM_LAT 2, 1, 4), each with a behavioural RAM;
// completions of instance 0 are checked against a queue of expected acks.
module tb_mio_mem_arbiter;

  localparam int unsigned N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, ram_init, cpu_we;
  logic [31:0]         cpu_addr, cpu_wdata, vga_addr;
  logic [N-1:0]        cpu_req, vga_req;
  logic [N-1:0][31:0]  cpu_rdata, vga_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [N-1:0]        mio_ready, vga_ack, mem_we;
  logic [N-1:0][1:0]   grant;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        cpu;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  function automatic logic [31:0] init_word(int i);
    return (i == 4) ? 32'h1234ABCD : (32'hA5A50000 | 32'(i));
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic [31:0] ram [64];

    mio_mem_arbiter #(.MEM_LAT(Lat), .AW(32), .DW(32)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req[g]),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata[g]),
      .MIO_ready (mio_ready[g]),
      .vga_req   (vga_req[g]),
      .vga_addr  (vga_addr),
      .vga_rdata (vga_rdata[g]),
      .vga_ack   (vga_ack[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_we    (mem_we[g]),
      .mem_rdata (mem_rdata[g]),
      .grant     (grant[g])
    );

    always @(posedge clk) begin
      if (ram_init) begin
        for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
      end else if (mem_we[g]) begin
        ram[mem_addr[g][5:0]] <= mem_wdata[g];
      end
    end

    if (Lat == 1) begin : g_comb
      assign mem_rdata[g] = ram[mem_addr[g][5:0]];
    end else begin : g_pipe
      logic [31:0] dly [Lat-1];
      always @(posedge clk) begin
        dly[0] <= ram[mem_addr[g][5:0]];
        for (int i = 1; i < int'(Lat) - 1; i++) dly[i] <= dly[i-1];
      end
      assign mem_rdata[g] = dly[Lat-2];
    end
  end

  // Scoreboard: every ack of instance 0 must match the oldest expected completion.
  always @(negedge clk) begin
    if (mio_ready[0] && vga_ack[0]) begin
      checks++;
      errors++;
      $display("FAIL ack_exclusive: MIO_ready=1 vga_ack=1, required at most one high");
    end
    if (mio_ready[0] || vga_ack[0]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: MIO_ready=%b vga_ack=%b, required no ack", mio_ready[0],
                 vga_ack[0]);
      end else begin
        mon_e = exp_q.pop_front();
        if (mio_ready[0] !== mon_e.cpu ||
            (mon_e.cpu ? cpu_rdata[0] : vga_rdata[0]) !== mon_e.data) begin
          errors++;
          $display("FAIL ack_data: cpu_side=%b data=%h, required cpu_side=%b data=%h",
                   mio_ready[0], mon_e.cpu ? cpu_rdata[0] : vga_rdata[0], mon_e.cpu,
                   mon_e.data);
        end
      end
    end
  end

  task automatic test_reset();
    logic bad = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant[0] !== 2'b00 || mio_ready[0] !== 1'b0 || vga_ack[0] !== 1'b0 ||
        mem_we[0] !== 1'b0 || mem_addr[0] !== 32'd0 || mem_wdata[0] !== 32'd0) begin
      errors++;
      $display("FAIL reset_ctrl: grant=%b mio=%b ack=%b we=%b addr=%h wdata=%h, required all 0",
               grant[0], mio_ready[0], vga_ack[0], mem_we[0], mem_addr[0], mem_wdata[0]);
    end
    checks++;
    if (cpu_rdata[0] !== 32'd0 || vga_rdata[0] !== 32'd0) begin
      errors++;
      $display("FAIL reset_rdata: cpu_rdata=%h vga_rdata=%h, required 0 0", cpu_rdata[0],
               vga_rdata[0]);
    end
    reset = 1'b0;
    ram_init = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (grant[0] !== 2'b00 || mio_ready[0] !== 1'b0 || vga_ack[0] !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_idle: activity seen after release, required grant=00 and no ack");
    end
  endtask

  task automatic test_cpu_read();
    int lat = 0;
    @(negedge clk);
    cpu_we = 1'b0;
    cpu_addr = 32'h0000_0010;
    cpu_req[0] = 1'b1;
    exp_q.push_back('{1'b1, 32'h1234ABCD});
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n <= 2) begin
        checks++;
        if (grant[0] !== 2'b01 || mem_addr[0] !== 32'd4 || mem_we[0] !== 1'b0) begin
          errors++;
          $display("FAIL cpu_read_bus c%0d: grant=%b addr=%h we=%b, required 01 00000004 0", n,
                   grant[0], mem_addr[0], mem_we[0]);
        end
      end
      if (mio_ready[0]) begin
        lat = n;
        cpu_req[0] = 1'b0;
      end
    end
    cpu_req[0] = 1'b0;
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL cpu_read_latency: ack after %0d edges, required 3", lat);
    end
  endtask

  task automatic test_cpu_write();
    int lat = 0;
    int we_cycles = 0;
    logic we_first = 1'b0;
    @(negedge clk);
    cpu_we = 1'b1;
    cpu_addr = 32'h0000_0020;
    cpu_wdata = 32'hDEADBEEF;
    cpu_req[0] = 1'b1;
    // A write leaves the previously read value in cpu_rdata.
    exp_q.push_back('{1'b1, 32'h1234ABCD});
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_we[0]) we_cycles++;
      if (n == 1) we_first = mem_we[0];
      if (n <= 2) begin
        checks++;
        if (grant[0] !== 2'b01 || mem_addr[0] !== 32'd8 || mem_wdata[0] !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL cpu_write_bus c%0d: grant=%b addr=%h wdata=%h, required 01 8 deadbeef",
                   n, grant[0], mem_addr[0], mem_wdata[0]);
        end
      end
      if (mio_ready[0]) begin
        lat = n;
        cpu_req[0] = 1'b0;
      end
    end
    cpu_req[0] = 1'b0;
    cpu_we = 1'b0;
    checks++;
    if (we_cycles != 1 || we_first !== 1'b1) begin
      errors++;
      $display("FAIL cpu_write_pulse: mem_we cycles=%0d first=%b, required 1 1", we_cycles,
               we_first);
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL cpu_write_latency: ack after %0d edges, required 3", lat);
    end
  endtask

  task automatic test_vga_readback();
    int lat = 0;
    @(negedge clk);
    vga_addr = 32'd8;
    vga_req[0] = 1'b1;
    exp_q.push_back('{1'b0, 32'hDEADBEEF});
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n <= 2) begin
        checks++;
        if (grant[0] !== 2'b10 || mem_addr[0] !== 32'd8 || mem_we[0] !== 1'b0) begin
          errors++;
          $display("FAIL vga_bus c%0d: grant=%b addr=%h we=%b, required 10 00000008 0", n,
                   grant[0], mem_addr[0], mem_we[0]);
        end
      end
      if (vga_ack[0]) begin
        lat = n;
        vga_req[0] = 1'b0;
      end
    end
    vga_req[0] = 1'b0;
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL vga_latency: ack after %0d edges, required 3", lat);
    end
  endtask

  task automatic test_tie();
    logic [1:0] exp_g;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cpu_we = 1'b0;
    cpu_addr = 32'h0000_0010;
    vga_addr = 32'd5;
    cpu_req[0] = 1'b1;
    vga_req[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('{1'b1, 32'h1234ABCD});
      exp_q.push_back('{1'b0, 32'hA5A50005});
    end
    reset = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      @(negedge clk);
      exp_g = (n % 3 == 2) ? 2'b00 : (((n / 3) % 2 == 0) ? 2'b01 : 2'b10);
      checks++;
      if (grant[0] !== exp_g) begin
        errors++;
        $display("FAIL tie_grant c%0d: grant=%b, required %b", n, grant[0], exp_g);
      end
      if (n == 11) begin
        cpu_req[0] = 1'b0;
        vga_req[0] = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL tie_acks: %0d expected acks outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic late_ack = 1'b0;
    @(negedge clk);
    cpu_we = 1'b1;
    cpu_addr = 32'h0000_0030;
    cpu_wdata = 32'hCAFEF00D;
    cpu_req[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_we[0] !== 1'b1 || grant[0] !== 2'b01) begin
      errors++;
      $display("FAIL abort_start: mem_we=%b grant=%b, required 1 01", mem_we[0], grant[0]);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cpu_req[0] = 1'b0;
    cpu_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant[0] !== 2'b00 || mem_we[0] !== 1'b0 || mio_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: grant=%b mem_we=%b mio=%b, required 00 0 0", grant[0],
               mem_we[0], mio_ready[0]);
    end
    reset = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (mio_ready[0] || grant[0] != 2'b00) late_ack = 1'b1;
    end
    checks++;
    if (late_ack) begin
      errors++;
      $display("FAIL abort_no_ack: ack or grant after abort, required none");
    end
    checks++;
    if (g_dut[0].ram[12] !== 32'hCAFEF00D || g_dut[0].ram[13] !== init_word(13)) begin
      errors++;
      $display("FAIL abort_ram: ram12=%h ram13=%h, required cafef00d %h", g_dut[0].ram[12],
               g_dut[0].ram[13], init_word(13));
    end
  endtask

  task automatic test_latency();
    int lat1 = 0;
    int lat4 = 0;
    @(negedge clk);
    vga_addr = 32'd4;
    vga_req[1] = 1'b1;
    vga_req[2] = 1'b1;
    for (int n = 1; n <= 12 && (lat1 == 0 || lat4 == 0); n++) begin
      @(posedge clk);
      @(negedge clk);
      if (vga_ack[1] && lat1 == 0) begin
        lat1 = n;
        vga_req[1] = 1'b0;
        checks++;
        if (vga_rdata[1] !== 32'h1234ABCD) begin
          errors++;
          $display("FAIL lat1_data: vga_rdata=%h, required 1234abcd", vga_rdata[1]);
        end
      end
      if (vga_ack[2] && lat4 == 0) begin
        lat4 = n;
        vga_req[2] = 1'b0;
        checks++;
        if (vga_rdata[2] !== 32'h1234ABCD) begin
          errors++;
          $display("FAIL lat4_data: vga_rdata=%h, required 1234abcd", vga_rdata[2]);
        end
      end
    end
    vga_req[1] = 1'b0;
    vga_req[2] = 1'b0;
    checks++;
    if (lat1 != 2) begin
      errors++;
      $display("FAIL lat1_latency: ack after %0d edges, required 2", lat1);
    end
    checks++;
    if (lat4 != 5) begin
      errors++;
      $display("FAIL lat4_latency: ack after %0d edges, required 5", lat4);
    end
  endtask

  initial begin
    reset = 1'b1;
    ram_init = 1'b1;
    cpu_req = '0;
    vga_req = '0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    vga_addr = '0;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_vga_readback();
    test_tie();
    test_reset_mid();
    test_latency();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d expected acks outstanding, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
